// File: rtl/valve_driver_pwm_if.sv
// Board-side bundle for the valve driver: serial frame input lines plus the
// per-channel drive enables and status outputs.
interface valve_driver_pwm_if #(
  parameter int unsigned CHANNEL_NUM = 48
);
  logic                   line_sclk;
  logic                   line_sen;
  logic                   line_sdata;
  logic [CHANNEL_NUM-1:0] signal_high_voltage;
  logic [CHANNEL_NUM-1:0] signal_low_voltage;
  logic                   frame_ok;
  logic                   frame_err;
  logic                   fault;
  logic [15:0]            frame_cnt;

  // Frame source / observer side.
  modport master (
    output line_sclk, line_sen, line_sdata,
    input  signal_high_voltage, signal_low_voltage, frame_ok, frame_err, fault, frame_cnt
  );

  // Driver side.
  modport slave (
    input  line_sclk, line_sen, line_sdata,
    output signal_high_voltage, signal_low_voltage, frame_ok, frame_err, fault, frame_cnt
  );
endinterface

// File: rtl/valve_driver_pwm.sv
// Valve board driver: glitch-filtered serial frame receiver, high-voltage kick on newly
// opened channels, PWM'd low-voltage hold, and overrun/watchdog shutdown.
module valve_driver_pwm #(
  parameter int unsigned CHANNEL_NUM  = 48,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned FILTER_DEPTH = 5,
  parameter int unsigned HV_TIME      = 4000,
  parameter int unsigned TIMEOUT      = 20000000,
  parameter int unsigned PWM_PERIOD   = 200,
  parameter int unsigned PWM_DUTY     = 200
) (
  input logic               sys_clk,
  input logic               rst,
  valve_driver_pwm_if.slave bus
);
  localparam int unsigned NB   = CHANNEL_NUM + PARITY_EN;  // bits in a valid frame
  localparam int unsigned CntW = $clog2(NB + 2);
  localparam int unsigned HvW  = (HV_TIME > 0) ? $clog2(HV_TIME + 1) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PwmW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  localparam logic [CntW-1:0] NbC      = CntW'(NB);
  localparam logic [CntW-1:0] CntMaxC  = CntW'(NB + 1);
  localparam logic [HvW-1:0]  HvLoadC  = HvW'(HV_TIME);
  localparam logic [WdW-1:0]  TmoC     = WdW'(TIMEOUT);
  localparam logic [PwmW-1:0] PwmLastC = PwmW'(PWM_PERIOD - 1);
  localparam logic [PwmW-1:0] PwmDutyC = PwmW'(PWM_DUTY);
  localparam bit              PwmFull  = (PWM_DUTY >= PWM_PERIOD);

  // Oldest sample low, FILTER_DEPTH newer samples high.
  localparam logic [FILTER_DEPTH:0] RisePat = {1'b0, {FILTER_DEPTH{1'b1}}};
  localparam logic [FILTER_DEPTH:0] FallPat = {1'b1, {FILTER_DEPTH{1'b0}}};

  logic [FILTER_DEPTH:0]  sclk_hist_q, sclk_hist_d, sen_hist_q, sen_hist_d;
  logic [FILTER_DEPTH:0]  sdata_hist_q, sdata_hist_d;
  logic                   sen_flt_q, sen_flt_d;
  logic [NB-1:0]          rx_bits_q, rx_bits_d;
  logic [CntW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [CHANNEL_NUM-1:0] cur_q, cur_d, prev_q, prev_d;
  logic [CHANNEL_NUM-1:0] hv_out_q, hv_out_d, lv_out_q, lv_out_d;
  logic [HvW-1:0]         hv_q, hv_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic [PwmW-1:0]        pwm_q, pwm_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   ok_q, ok_d, err_q, err_d, ovr_q, ovr_d;

  logic sclk_rise, sen_rise, sen_fall, sdata_flt, wd_fault, fault_act;
  logic len_ok, par_ok, frame_end, accept, reject, bit_strobe, pwm_on, hv_win;
  logic [CHANNEL_NUM-1:0] hv_mask;

  assign sclk_rise  = (sclk_hist_q == RisePat);
  assign sen_rise   = (sen_hist_q == RisePat);
  assign sen_fall   = (sen_hist_q == FallPat);
  assign sdata_flt  = sdata_hist_q[FILTER_DEPTH];
  assign wd_fault   = (wd_q == TmoC);
  assign fault_act  = ovr_q | wd_fault;
  assign len_ok     = (rx_cnt_q == NbC);
  assign par_ok     = (PARITY_EN == 0) || !(^rx_bits_q);
  assign frame_end  = sen_fall && !fault_act;
  assign accept     = frame_end && len_ok && par_ok;
  assign reject     = frame_end && !(len_ok && par_ok);
  // An sclk edge coinciding with the frame end is dropped.
  assign bit_strobe = sen_flt_q && sclk_rise && !sen_fall && !fault_act;
  assign hv_win     = (hv_q != '0);
  assign hv_mask    = prev_q & ~cur_q;
  assign pwm_on     = PwmFull || (pwm_q < PwmDutyC);

  // Input history shift (newest at bit 0) and filtered sen level.
  always_comb begin
    sclk_hist_d  = {sclk_hist_q[FILTER_DEPTH-1:0], bus.line_sclk};
    sen_hist_d   = {sen_hist_q[FILTER_DEPTH-1:0], bus.line_sen};
    sdata_hist_d = {sdata_hist_q[FILTER_DEPTH-1:0], bus.line_sdata};
    sen_flt_d    = sen_flt_q;
    if (sen_rise) begin
      sen_flt_d = 1'b1;
    end else if (sen_fall) begin
      sen_flt_d = 1'b0;
    end
  end

  // Bit reception, overrun detection and watchdog counting.
  always_comb begin
    rx_bits_d = rx_bits_q;
    rx_cnt_d  = rx_cnt_q;
    ovr_d     = ovr_q;
    wd_d      = wd_q;
    if (fault_act || sen_fall) begin
      rx_cnt_d = '0;
    end else if (bit_strobe) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (rx_cnt_q == CntW'(k)) begin
          rx_bits_d[k] = sdata_flt;
        end
      end
      if (rx_cnt_q != CntMaxC) begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
    if (sen_rise) begin
      ovr_d = 1'b0;
    end else if (sen_flt_q && (rx_cnt_q > NbC)) begin
      ovr_d = 1'b1;
    end
    if (sclk_rise) begin
      wd_d = '0;
    end else if (!wd_fault) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Frame registers, HV timer, status pulses and frame counter.
  always_comb begin
    cur_d       = cur_q;
    prev_d      = prev_q;
    hv_d        = hv_q;
    frame_cnt_d = frame_cnt_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    if (fault_act) begin
      cur_d  = '1;
      prev_d = '1;
      hv_d   = '0;
    end else begin
      if (hv_win) begin
        hv_d = hv_q - 1'b1;
      end
      if (accept) begin
        prev_d      = cur_q;
        cur_d       = rx_bits_q[CHANNEL_NUM-1:0];
        frame_cnt_d = frame_cnt_q + 16'd1;
        hv_d        = HvLoadC;
        ok_d        = 1'b1;
      end
      err_d = reject;
    end
  end

  // PWM phase (restarted when the HV window closes) and registered drive outputs.
  always_comb begin
    pwm_d = (pwm_q == PwmLastC) ? '0 : pwm_q + 1'b1;
    if (hv_win && (hv_d == '0)) begin
      pwm_d = '0;
    end
    if (fault_act) begin
      hv_out_d = '1;
      lv_out_d = '1;
    end else if (hv_win) begin
      hv_out_d = ~hv_mask;
      lv_out_d = cur_q;
    end else begin
      hv_out_d = '1;
      lv_out_d = cur_q | {CHANNEL_NUM{~pwm_on}};
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sclk_hist_q  <= '0;
      sen_hist_q   <= '0;
      sdata_hist_q <= '0;
      sen_flt_q    <= 1'b0;
      rx_bits_q    <= '0;
      rx_cnt_q     <= '0;
      ovr_q        <= 1'b0;
      wd_q         <= '0;
      cur_q        <= '1;
      prev_q       <= '1;
      hv_q         <= '0;
      frame_cnt_q  <= '0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      pwm_q        <= '0;
      hv_out_q     <= '1;
      lv_out_q     <= '1;
    end else begin
      sclk_hist_q  <= sclk_hist_d;
      sen_hist_q   <= sen_hist_d;
      sdata_hist_q <= sdata_hist_d;
      sen_flt_q    <= sen_flt_d;
      rx_bits_q    <= rx_bits_d;
      rx_cnt_q     <= rx_cnt_d;
      ovr_q        <= ovr_d;
      wd_q         <= wd_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      hv_q         <= hv_d;
      frame_cnt_q  <= frame_cnt_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      pwm_q        <= pwm_d;
      hv_out_q     <= hv_out_d;
      lv_out_q     <= lv_out_d;
    end
  end

  assign bus.signal_high_voltage = hv_out_q;
  assign bus.signal_low_voltage  = lv_out_q;
  assign bus.frame_ok            = ok_q;
  assign bus.frame_err           = err_q;
  assign bus.fault               = fault_act;
  assign bus.frame_cnt           = frame_cnt_q;
endmodule

// File: tb/tb_valve_driver_pwm.sv
// Bench for valve_driver_pwm: directed scenarios plus randomized frames checked
// against a frame-level model of the valve state (current/previous mask, counter).
module tb_valve_driver_pwm;
  localparam int CH  = 8;
  localparam int FD  = 5;
  localparam int HVT = 10;
  localparam int TMO = 1000;
  localparam int PP  = 4;
  localparam int PD  = 2;
  localparam int MON = 40;

  logic sys_clk = 1'b0;
  logic rst;

  valve_driver_pwm_if #(.CHANNEL_NUM(CH)) bus ();

  valve_driver_pwm #(
    .CHANNEL_NUM (CH),
    .PARITY_EN   (1),
    .FILTER_DEPTH(FD),
    .HV_TIME     (HVT),
    .TIMEOUT     (TMO),
    .PWM_PERIOD  (PP),
    .PWM_DUTY    (PD)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [7:0]  m_cur, m_prev;
  logic [15:0] m_cnt;
  logic        fault_at_start;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Data byte plus trailing even-parity bit; bad=1 corrupts the parity.
  function automatic logic [15:0] mk(input logic [7:0] d, input logic bad);
    mk = {7'd0, (^d) ^ bad, d};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.line_sdata = b;
    cyc(3);
    bus.line_sclk = 1'b1;
    cyc(8);
    bus.line_sclk = 1'b0;
    cyc(8);
  endtask

  task automatic send_frame(input logic [15:0] bits, input int nbits);
    bus.line_sen = 1'b1;
    cyc(8);
    fault_at_start = bus.fault;
    for (int k = 0; k < nbits; k++) send_bit(bits[k]);
    cyc(8);
    bus.line_sen = 1'b0;
  endtask

  // Update the model for one finished frame, then watch MON cycles of outputs.
  task automatic expect_frame(input logic [15:0] bits, input int nbits, input bit faulted);
    logic       acc;
    logic [8:0] fb;
    logic [7:0] mask, exp_lv;
    logic [7:0] hv_t [MON];
    logic [7:0] lv_t [MON];
    int ok_c, err_c, ok_at, m;
    fb  = bits[8:0];
    acc = !faulted && (nbits == 9) && ((^fb) == 1'b0);
    if (acc) begin
      m_prev = m_cur;
      m_cur  = bits[7:0];
      m_cnt  = m_cnt + 16'd1;
    end
    mask  = m_prev & ~m_cur;
    ok_c  = 0;
    err_c = 0;
    ok_at = -1;
    for (int c = 0; c < MON; c++) begin
      @(negedge sys_clk);
      hv_t[c] = bus.signal_high_voltage;
      lv_t[c] = bus.signal_low_voltage;
      if (bus.frame_ok) begin
        ok_c++;
        if (ok_at < 0) ok_at = c;
      end
      if (bus.frame_err) err_c++;
    end
    check_eq("frame_ok pulses", 32'(ok_c), {31'd0, acc});
    check_eq("frame_err pulses", 32'(err_c), {31'd0, !acc && !faulted});
    check_eq("frame_cnt", {16'd0, bus.frame_cnt}, {16'd0, m_cnt});
    check_eq("fault level", {31'd0, bus.fault}, {31'd0, faulted});
    if (acc && ok_at >= 0) begin
      check_eq("ok latency", {31'd0, (ok_at >= FD) && (ok_at <= FD + 3)}, 32'd1);
      for (int c = 0; c < MON; c++) begin
        if (c <= ok_at) begin
          check_eq("hv before window", {24'd0, hv_t[c]}, 32'hFF);
        end else if (c <= ok_at + HVT) begin
          check_eq("hv in window", {24'd0, hv_t[c]}, {24'd0, ~mask});
          check_eq("lv in window", {24'd0, lv_t[c]}, {24'd0, m_cur});
        end else begin
          m      = c - ok_at - HVT - 1;
          exp_lv = ((m % PP) < PD) ? m_cur : 8'hFF;
          check_eq("hv after window", {24'd0, hv_t[c]}, 32'hFF);
          check_eq("lv pwm hold", {24'd0, lv_t[c]}, {24'd0, exp_lv});
        end
      end
    end else begin
      for (int c = 0; c < MON; c++) begin
        check_eq("hv idle", {24'd0, hv_t[c]}, 32'hFF);
        if (faulted) check_eq("lv off in fault", {24'd0, lv_t[c]}, 32'hFF);
        else check_eq("lv closed bits stay off", {24'd0, ~lv_t[c] & m_cur}, 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    logic [15:0] b;
    int nb, kind;
    rst            = 1'b1;
    bus.line_sclk  = 1'b0;
    bus.line_sen   = 1'b0;
    bus.line_sdata = 1'b0;
    m_cur  = 8'hFF;
    m_prev = 8'hFF;
    m_cnt  = 16'd0;
    cyc(3);
    check_eq("reset hv", {24'd0, bus.signal_high_voltage}, 32'hFF);
    check_eq("reset lv", {24'd0, bus.signal_low_voltage}, 32'hFF);
    check_eq("reset ok", {31'd0, bus.frame_ok}, 32'd0);
    check_eq("reset err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("reset fault", {31'd0, bus.fault}, 32'd0);
    check_eq("reset cnt", {16'd0, bus.frame_cnt}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // Basic accept, repeated mask, newly opened channel only.
    send_frame(mk(8'hF0, 1'b0), 9); expect_frame(mk(8'hF0, 1'b0), 9, 1'b0);
    send_frame(mk(8'hF0, 1'b0), 9); expect_frame(mk(8'hF0, 1'b0), 9, 1'b0);
    send_frame(mk(8'hE0, 1'b0), 9); expect_frame(mk(8'hE0, 1'b0), 9, 1'b0);

    // Bad parity and missing parity bit.
    send_frame(mk(8'hF0, 1'b1), 9); expect_frame(mk(8'hF0, 1'b1), 9, 1'b0);
    send_frame(mk(8'hF0, 1'b0), 8); expect_frame(mk(8'hF0, 1'b0), 8, 1'b0);

    // Randomized frames: mostly valid, some bad parity, some short.
    for (int t = 0; t < 30; t++) begin
      b    = 16'($urandom);
      b    = mk(b[7:0], 1'b0);
      nb   = 9;
      kind = int'($urandom_range(0, 9));
      if (kind == 7) b[8] = ~b[8];
      else if (kind >= 8) nb = int'($urandom_range(1, 8));
      send_frame(b, nb);
      expect_frame(b, nb, 1'b0);
    end

    // Overrun: 11 clocks in one frame.
    m_cur  = 8'hFF;
    m_prev = 8'hFF;
    b = 16'($urandom);
    send_frame(b, 11);
    expect_frame(b, 11, 1'b1);
    send_frame(mk(8'h3C, 1'b0), 9);
    check_eq("overrun cleared at sen rise", {31'd0, fault_at_start}, 32'd0);
    expect_frame(mk(8'h3C, 1'b0), 9, 1'b0);

    // Watchdog: idle sclk.
    cyc(850);
    check_eq("wd not yet", {31'd0, bus.fault}, 32'd0);
    cyc(200);
    check_eq("wd fault", {31'd0, bus.fault}, 32'd1);
    check_eq("wd hv off", {24'd0, bus.signal_high_voltage}, 32'hFF);
    check_eq("wd lv off", {24'd0, bus.signal_low_voltage}, 32'hFF);
    check_eq("wd cnt hold", {16'd0, bus.frame_cnt}, {16'd0, m_cnt});
    m_cur  = 8'hFF;
    m_prev = 8'hFF;
    bus.line_sclk = 1'b1;
    cyc(8);
    bus.line_sclk = 1'b0;
    cyc(8);
    check_eq("wd cleared", {31'd0, bus.fault}, 32'd0);
    check_eq("wd cnt after", {16'd0, bus.frame_cnt}, {16'd0, m_cnt});
    check_eq("wd lv after", {24'd0, bus.signal_low_voltage}, 32'hFF);

    // Counter wrap from a preset value.
    force dut.frame_cnt_q = 16'hFFFE;
    cyc(1);
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFE;
    cyc(1);
    check_eq("cnt preset", {16'd0, bus.frame_cnt}, {16'd0, m_cnt});
    send_frame(mk(8'h3C, 1'b0), 9); expect_frame(mk(8'h3C, 1'b0), 9, 1'b0);
    send_frame(mk(8'hA5, 1'b0), 9); expect_frame(mk(8'hA5, 1'b0), 9, 1'b0);
    send_frame(mk(8'h0F, 1'b0), 9); expect_frame(mk(8'h0F, 1'b0), 9, 1'b0);

    // Reset in the middle of a frame.
    bus.line_sen = 1'b1;
    cyc(8);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst hv", {24'd0, bus.signal_high_voltage}, 32'hFF);
    check_eq("midrst lv", {24'd0, bus.signal_low_voltage}, 32'hFF);
    check_eq("midrst cnt", {16'd0, bus.frame_cnt}, 32'd0);
    check_eq("midrst fault", {31'd0, bus.fault}, 32'd0);
    bus.line_sen  = 1'b0;
    bus.line_sclk = 1'b0;
    cyc(3);
    rst = 1'b0;
    m_cur  = 8'hFF;
    m_prev = 8'hFF;
    m_cnt  = 16'd0;
    cyc(10);
    send_frame(mk(8'h5A, 1'b0), 9); expect_frame(mk(8'h5A, 1'b0), 9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
